// File: rtl/axi_mem_resp_pkg.sv
// Shared types, burst/response constants and the burst address helper
// for the AXI memory responder.
package axi_mem_resp_pkg;

    localparam int unsigned AddrW = 64;
    localparam int unsigned DataW = 64;
    localparam int unsigned IdW   = 4;
    localparam int unsigned StrbW = DataW / 8;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_FETCH,
        RD_SEND
    } rd_state_e;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_DATA,
        WR_RESP
    } wr_state_e;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic             lock;
    } ax_chan_t;

    typedef struct packed {
        logic [DataW-1:0] data;
        logic [StrbW-1:0] strb;
        logic             last;
    } w_chan_t;

    typedef struct packed {
        logic [IdW-1:0] id;
        logic [1:0]     resp;
    } b_chan_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [DataW-1:0] data;
        logic [1:0]       resp;
        logic             last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        r_chan_t r;
        logic    r_valid;
    } resp_t;

    function automatic logic wrap_bad(input logic [1:0] burst,
                                      input logic [7:0] len);
        return (burst == BURST_WRAP) &&
               !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
    endfunction

    // Higher code wins: DECERR > SLVERR > EXOKAY > OKAY.
    function automatic logic [1:0] resp_merge(input logic [1:0] a,
                                              input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [AddrW-1:0] next_addr(
        input logic [AddrW-1:0] addr,
        input logic [2:0]       size,
        input logic [7:0]       len,
        input logic [1:0]       burst
    );
        logic [AddrW-1:0] step;
        logic [AddrW-1:0] mask;
        logic [AddrW-1:0] nxt;
        logic [AddrW-1:0] res;
        step = AddrW'(1) << size;
        mask = ((AddrW'(len) + AddrW'(1)) << size) - AddrW'(1);
        nxt  = addr + step;
        if (burst == BURST_FIXED) begin
            res = addr;
        end else if (burst == BURST_WRAP && !wrap_bad(burst, len)) begin
            res = (addr & ~mask) | (nxt & mask);
        end else begin
            res = nxt;
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_mem_resp_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts;
// illegal WRAP lengths fall back to INCR stepping.
module axi_mem_resp_addr_gen
    import axi_mem_resp_pkg::*;
(
    input  logic [AddrW-1:0] addr_i,
    input  logic [2:0]       size_i,
    input  logic [7:0]       len_i,
    input  logic [1:0]       burst_i,
    output logic [AddrW-1:0] next_addr_o
);

    always_comb begin
        next_addr_o = next_addr(addr_i, size_i, len_i, burst_i);
    end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 memory responder with independent read and write FSMs.
// Define AXI_MEM_RESPONDER_EXCL_EN to enable exclusive-access monitoring.
module axi_mem_responder
    import axi_mem_resp_pkg::*;
#(
    parameter int unsigned AxiAddrWidth = AddrW,
    parameter int unsigned AxiDataWidth = DataW,
    parameter int unsigned AxiIdWidth   = IdW,
    parameter int unsigned MemWords     = 4096,
    parameter type         axi_req_t    = req_t,
    parameter type         axi_rsp_t    = resp_t
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  axi_req_t axi_req_i,
    output axi_rsp_t axi_resp_o
);

    localparam int unsigned Lanes = AxiDataWidth / 8;
    localparam int unsigned OffW  = $clog2(Lanes);
    localparam int unsigned IdxW  = $clog2(MemWords);
    localparam int unsigned TopW  = OffW + IdxW;

    logic [AxiDataWidth-1:0] mem_q [MemWords];

    rd_state_e rd_state_q, rd_state_d;
    wr_state_e wr_state_q, wr_state_d;

    logic [AxiIdWidth-1:0]   rid_q;
    logic [AxiAddrWidth-1:0] raddr_q;
    logic [AxiAddrWidth-1:0] rnext;
    logic [7:0]              rlen_q;
    logic [7:0]              rbeat_q;
    logic [2:0]              rsize_q;
    logic [1:0]              rburst_q;
    logic [1:0]              rbase_q;
    logic [1:0]              rresp_q;
    logic [AxiDataWidth-1:0] rdata_q;

    logic [AxiIdWidth-1:0]   wid_q;
    logic [AxiAddrWidth-1:0] waddr_q;
    logic [AxiAddrWidth-1:0] wnext;
    logic [7:0]              wlen_q;
    logic [7:0]              wbeat_q;
    logic [2:0]              wsize_q;
    logic [1:0]              wburst_q;
    logic [1:0]              wresp_q;
    logic                    wsupp_q;

    logic            ar_fire, r_fire, rlast, rdec;
    logic            aw_fire, w_fire, wdec, wmiss;
    logic [IdxW-1:0] ridx, widx;
    logic            ar_excl, aw_excl_ok, aw_excl_bad;

    assign ar_fire = (rd_state_q == RD_IDLE) && axi_req_i.ar_valid;
    assign r_fire  = (rd_state_q == RD_SEND) && axi_req_i.r_ready;
    assign rlast   = (rbeat_q == rlen_q);
    assign ridx    = raddr_q[OffW +: IdxW];
    assign rdec    = |raddr_q[AxiAddrWidth-1:TopW];

    assign aw_fire = (wr_state_q == WR_IDLE) && axi_req_i.aw_valid;
    assign w_fire  = (wr_state_q == WR_DATA) && axi_req_i.w_valid;
    assign widx    = waddr_q[OffW +: IdxW];
    assign wdec    = |waddr_q[AxiAddrWidth-1:TopW];
    assign wmiss   = (wbeat_q == wlen_q) && !axi_req_i.w.last;

    axi_mem_resp_addr_gen i_rd_agen (
        .addr_i      (raddr_q),
        .size_i      (rsize_q),
        .len_i       (rlen_q),
        .burst_i     (rburst_q),
        .next_addr_o (rnext)
    );

    axi_mem_resp_addr_gen i_wr_agen (
        .addr_i      (waddr_q),
        .size_i      (wsize_q),
        .len_i       (wlen_q),
        .burst_i     (wburst_q),
        .next_addr_o (wnext)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_state_q <= RD_IDLE;
            wr_state_q <= WR_IDLE;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        unique case (rd_state_q)
            RD_IDLE:  if (axi_req_i.ar_valid) rd_state_d = RD_FETCH;
            RD_FETCH: rd_state_d = RD_SEND;
            RD_SEND: begin
                if (axi_req_i.r_ready) begin
                    rd_state_d = rlast ? RD_IDLE : RD_FETCH;
                end
            end
            default:  rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        unique case (wr_state_q)
            WR_IDLE: if (axi_req_i.aw_valid) wr_state_d = WR_DATA;
            WR_DATA: begin
                if (w_fire && (axi_req_i.w.last || rbeat_eq_len())) begin
                    wr_state_d = WR_RESP;
                end
            end
            WR_RESP: if (axi_req_i.b_ready) wr_state_d = WR_IDLE;
            default: wr_state_d = WR_IDLE;
        endcase
    end

    function automatic logic rbeat_eq_len();
        return wbeat_q == wlen_q;
    endfunction

    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.ar_ready = !rst_i && (rd_state_q == RD_IDLE);
        axi_resp_o.r_valid  = (rd_state_q == RD_SEND);
        axi_resp_o.r.id     = rid_q;
        axi_resp_o.r.data   = rdata_q;
        axi_resp_o.r.resp   = rresp_q;
        axi_resp_o.r.last   = (rd_state_q == RD_SEND) && rlast;
        axi_resp_o.aw_ready = !rst_i && (wr_state_q == WR_IDLE);
        axi_resp_o.w_ready  = (wr_state_q == WR_DATA);
        axi_resp_o.b_valid  = (wr_state_q == WR_RESP);
        axi_resp_o.b.id     = wid_q;
        axi_resp_o.b.resp   = wresp_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rid_q    <= '0;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rbeat_q  <= '0;
            rsize_q  <= '0;
            rburst_q <= '0;
            rbase_q  <= RESP_OKAY;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            if (ar_fire) begin
                rid_q    <= axi_req_i.ar.id;
                raddr_q  <= axi_req_i.ar.addr;
                rlen_q   <= axi_req_i.ar.len;
                rbeat_q  <= '0;
                rsize_q  <= axi_req_i.ar.size;
                rburst_q <= axi_req_i.ar.burst;
                if (wrap_bad(axi_req_i.ar.burst, axi_req_i.ar.len)) begin
                    rbase_q <= RESP_SLVERR;
                end else begin
                    rbase_q <= ar_excl ? RESP_EXOKAY : RESP_OKAY;
                end
            end
            // Old data wins over a same-cycle write to the same word.
            if (rd_state_q == RD_FETCH) begin
                rdata_q <= rdec ? '0 : mem_q[ridx];
                rresp_q <= rdec ? RESP_DECERR : rbase_q;
            end
            if (r_fire && !rlast) begin
                raddr_q <= rnext;
                rbeat_q <= rbeat_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wid_q    <= '0;
            waddr_q  <= '0;
            wlen_q   <= '0;
            wbeat_q  <= '0;
            wsize_q  <= '0;
            wburst_q <= '0;
            wresp_q  <= RESP_OKAY;
            wsupp_q  <= 1'b0;
        end else begin
            if (aw_fire) begin
                wid_q    <= axi_req_i.aw.id;
                waddr_q  <= axi_req_i.aw.addr;
                wlen_q   <= axi_req_i.aw.len;
                wbeat_q  <= '0;
                wsize_q  <= axi_req_i.aw.size;
                wburst_q <= axi_req_i.aw.burst;
                wsupp_q  <= aw_excl_bad;
                if (wrap_bad(axi_req_i.aw.burst, axi_req_i.aw.len)) begin
                    wresp_q <= RESP_SLVERR;
                end else begin
                    wresp_q <= aw_excl_ok ? RESP_EXOKAY : RESP_OKAY;
                end
            end
            if (w_fire) begin
                waddr_q <= wnext;
                wbeat_q <= wbeat_q + 8'd1;
                if (wdec) begin
                    wresp_q <= RESP_DECERR;
                end else if (wmiss) begin
                    wresp_q <= resp_merge(wresp_q, RESP_SLVERR);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_fire && !wdec && !wsupp_q) begin
            for (int i = 0; i < Lanes; i++) begin
                if (axi_req_i.w.strb[i]) begin
                    mem_q[widx][i*8 +: 8] <= axi_req_i.w.data[i*8 +: 8];
                end
            end
        end
    end

`ifdef AXI_MEM_RESPONDER_EXCL_EN
    logic                  resv_valid_q;
    logic [AxiIdWidth-1:0] resv_id_q;
    logic [IdxW-1:0]       resv_idx_q;
    logic                  wlock_q;

    assign ar_excl     = axi_req_i.ar.lock;
    assign aw_excl_ok  = axi_req_i.aw.lock && resv_valid_q &&
                         (resv_id_q == axi_req_i.aw.id) &&
                         (resv_idx_q == axi_req_i.aw.addr[OffW +: IdxW]);
    assign aw_excl_bad = axi_req_i.aw.lock && !aw_excl_ok;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resv_valid_q <= 1'b0;
            resv_id_q    <= '0;
            resv_idx_q   <= '0;
            wlock_q      <= 1'b0;
        end else begin
            if (aw_fire) begin
                wlock_q <= axi_req_i.aw.lock;
            end
            if (aw_fire && aw_excl_ok) begin
                resv_valid_q <= 1'b0;
            end
            if (w_fire && !wlock_q && !wdec && (widx == resv_idx_q)) begin
                resv_valid_q <= 1'b0;
            end
            if (ar_fire && ar_excl) begin
                resv_valid_q <= 1'b1;
                resv_id_q    <= axi_req_i.ar.id;
                resv_idx_q   <= axi_req_i.ar.addr[OffW +: IdxW];
            end
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^{axi_req_i.ar.lock, axi_req_i.aw.lock};
    assign ar_excl     = 1'b0;
    assign aw_excl_ok  = 1'b0;
    assign aw_excl_bad = 1'b0;
`endif

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed self-checking bench for axi_mem_responder.
// Exclusive checks follow AXI_MEM_RESPONDER_EXCL_EN.
module tb_axi_mem_responder;
    import axi_mem_resp_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    req_t  req;
    resp_t rsp;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_d [16];
    logic [3:0]  bid;
    logic [1:0]  br;
    int          lat;

    always #5 clk = ~clk;

    axi_mem_responder dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .axi_req_i  (req),
        .axi_resp_o (rsp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    task automatic send_ar(input logic [63:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] id,
                           input logic lock);
        int n;
        n = 0;
        while (!rsp.ar_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) timeout_fail("ar_ready");
        req.ar.addr  = addr;
        req.ar.len   = len;
        req.ar.size  = 3'd3;
        req.ar.burst = burst;
        req.ar.id    = id;
        req.ar.lock  = lock;
        req.ar_valid = 1'b1;
        tick();
        req.ar_valid = 1'b0;
    endtask

    task automatic recv_r(input string tag, input int beats,
                          input logic [3:0] id, input logic [1:0] resp);
        int n;
        for (int b = 0; b < beats; b++) begin
            n = 0;
            req.r_ready = 1'b1;
            while (!rsp.r_valid && n < 20) begin
                tick();
                n++;
            end
            if (n >= 20) begin
                timeout_fail($sformatf("%s_rvalid%0d", tag, b));
                req.r_ready = 1'b0;
                return;
            end
            chk($sformatf("%s_data%0d", tag, b), rsp.r.data, exp_d[b]);
            chk($sformatf("%s_id%0d", tag, b), 64'(rsp.r.id), 64'(id));
            chk($sformatf("%s_resp%0d", tag, b), 64'(rsp.r.resp), 64'(resp));
            chk($sformatf("%s_last%0d", tag, b), 64'(rsp.r.last),
                64'(b == beats - 1));
            tick();
        end
        req.r_ready = 1'b0;
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [7:0] len,
                            input logic [3:0] id, input logic lock,
                            input logic [63:0] dbase, input logic [7:0] strb,
                            input logic give_last,
                            output logic [3:0] b_id, output logic [1:0] b_resp);
        int n;
        n = 0;
        b_id = '0;
        b_resp = '0;
        while (!rsp.aw_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) timeout_fail("aw_ready");
        req.aw.addr  = addr;
        req.aw.len   = len;
        req.aw.size  = 3'd3;
        req.aw.burst = BURST_INCR;
        req.aw.id    = id;
        req.aw.lock  = lock;
        req.aw_valid = 1'b1;
        tick();
        req.aw_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            req.w.data = dbase + 64'(i);
            req.w.strb = strb;
            req.w.last = give_last && (i == int'(len));
            req.w_valid = 1'b1;
            n = 0;
            while (!rsp.w_ready && n < 20) begin
                tick();
                n++;
            end
            if (n >= 20) timeout_fail("w_ready");
            tick();
        end
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
        req.b_ready = 1'b1;
        n = 0;
        while (!rsp.b_valid && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) timeout_fail("b_valid");
        b_id   = rsp.b.id;
        b_resp = rsp.b.resp;
        tick();
        req.b_ready = 1'b0;
    endtask

    task automatic read_one(input string tag, input logic [63:0] addr,
                            input logic [63:0] exp);
        send_ar(addr, 8'd0, BURST_INCR, 4'h0, 1'b0);
        exp_d[0] = exp;
        recv_r(tag, 1, 4'h0, RESP_OKAY);
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        repeat (3) tick();
        chk("rst_ar_ready", 64'(rsp.ar_ready), 64'd0);
        chk("rst_aw_ready", 64'(rsp.aw_ready), 64'd0);
        chk("rst_r_valid", 64'(rsp.r_valid), 64'd0);
        chk("rst_b_valid", 64'(rsp.b_valid), 64'd0);
        chk("rst_r_data", rsp.r.data, 64'd0);
        chk("rst_b_id", 64'(rsp.b.id), 64'd0);
        rst = 1'b0;
        #1;
        chk("idle_ar_ready", 64'(rsp.ar_ready), 64'd1);
        chk("idle_aw_ready", 64'(rsp.aw_ready), 64'd1);
        chk("idle_w_ready", 64'(rsp.w_ready), 64'd0);

        do_write(64'h40, 8'd7, 4'b1100, 1'b0, 64'hD000_0000_0000_0040,
                 8'hFF, 1'b1, bid, br);
        chk("pre1_bid", 64'(bid), 64'hC);
        chk("pre1_bresp", 64'(br), 64'(RESP_OKAY));
        do_write(64'h20, 8'd3, 4'b0000, 1'b0, 64'hC000_0000_0000_0000,
                 8'hFF, 1'b1, bid, br);
        chk("pre2_bresp", 64'(br), 64'(RESP_OKAY));

        send_ar(64'h40, 8'd7, BURST_INCR, 4'b1100, 1'b0);
        lat = 1;
        while (!rsp.r_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("rd_latency", 64'(lat), 64'd2);
        for (int i = 0; i < 8; i++) exp_d[i] = 64'hD000_0000_0000_0040 + 64'(i);
        recv_r("incr8", 8, 4'b1100, RESP_OKAY);

        send_ar(64'h30, 8'd3, BURST_WRAP, 4'b0000, 1'b0);
        exp_d[0] = 64'hC000_0000_0000_0002;
        exp_d[1] = 64'hC000_0000_0000_0003;
        exp_d[2] = 64'hC000_0000_0000_0000;
        exp_d[3] = 64'hC000_0000_0000_0001;
        recv_r("wrap4", 4, 4'b0000, RESP_OKAY);

        send_ar(64'h20, 8'd2, BURST_WRAP, 4'b0011, 1'b0);
        exp_d[0] = 64'hC000_0000_0000_0000;
        exp_d[1] = 64'hC000_0000_0000_0001;
        exp_d[2] = 64'hC000_0000_0000_0002;
        recv_r("badwrap", 3, 4'b0011, RESP_SLVERR);

        send_ar(64'h48, 8'd2, BURST_FIXED, 4'b1000, 1'b0);
        for (int i = 0; i < 3; i++) exp_d[i] = 64'hD000_0000_0000_0041;
        recv_r("fixed", 3, 4'b1000, RESP_OKAY);

        do_write(64'h100, 8'd0, 4'b0000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF,
                 8'hFF, 1'b1, bid, br);
        do_write(64'h100, 8'd0, 4'b1001, 1'b0, 64'h1122_3344_5566_7788,
                 8'h0F, 1'b1, bid, br);
        chk("strb_bid", 64'(bid), 64'h9);
        chk("strb_bresp", 64'(br), 64'(RESP_OKAY));
        read_one("strb_rd", 64'h100, 64'hFFFF_FFFF_5566_7788);

        do_write(64'h180, 8'd1, 4'b1010, 1'b0, 64'h5, 8'hFF, 1'b0, bid, br);
        chk("nolast_bid", 64'(bid), 64'hA);
        chk("nolast_bresp", 64'(br), 64'(RESP_SLVERR));

        send_ar(64'h40, 8'd3, BURST_INCR, 4'b1000, 1'b0);
        req.r_ready = 1'b0;
        lat = 0;
        while (!rsp.r_valid && lat < 20) begin
            tick();
            lat++;
        end
        do_write(64'h300, 8'd0, 4'b1011, 1'b0, 64'h0000_0000_0000_BEEF,
                 8'hFF, 1'b1, bid, br);
        repeat (2) tick();
        chk("bp_bid", 64'(bid), 64'hB);
        chk("bp_bresp", 64'(br), 64'(RESP_OKAY));
        chk("bp_rvalid", 64'(rsp.r_valid), 64'd1);
        chk("bp_rdata", rsp.r.data, 64'hD000_0000_0000_0040);
        chk("bp_rid", 64'(rsp.r.id), 64'h8);
        chk("bp_rlast", 64'(rsp.r.last), 64'd0);
        for (int i = 0; i < 4; i++) exp_d[i] = 64'hD000_0000_0000_0040 + 64'(i);
        recv_r("bp", 4, 4'b1000, RESP_OKAY);
        read_one("bp_wr_rd", 64'h300, 64'h0000_0000_0000_BEEF);

        send_ar(64'h0010_0040, 8'd3, BURST_INCR, 4'b1010, 1'b0);
        for (int i = 0; i < 4; i++) exp_d[i] = 64'd0;
        recv_r("decerr", 4, 4'b1010, RESP_DECERR);

        do_write(64'h200, 8'd0, 4'b0000, 1'b0, 64'd0, 8'hFF, 1'b1, bid, br);
        send_ar(64'h200, 8'd0, BURST_INCR, 4'b0010, 1'b1);
        exp_d[0] = 64'd0;
`ifdef AXI_MEM_RESPONDER_EXCL_EN
        recv_r("ex_rd", 1, 4'b0010, RESP_EXOKAY);
        do_write(64'h200, 8'd0, 4'b0010, 1'b1, 64'hAAAA, 8'hFF, 1'b1, bid, br);
        chk("ex_wr1_bresp", 64'(br), 64'(RESP_EXOKAY));
        read_one("ex_rd1", 64'h200, 64'hAAAA);
        do_write(64'h200, 8'd0, 4'b0010, 1'b1, 64'hBBBB, 8'hFF, 1'b1, bid, br);
        chk("ex_wr2_bresp", 64'(br), 64'(RESP_OKAY));
        read_one("ex_rd2", 64'h200, 64'hAAAA);
`else
        recv_r("ex_rd", 1, 4'b0010, RESP_OKAY);
        do_write(64'h200, 8'd0, 4'b0010, 1'b1, 64'hAAAA, 8'hFF, 1'b1, bid, br);
        chk("ex_wr1_bresp", 64'(br), 64'(RESP_OKAY));
        read_one("ex_rd1", 64'h200, 64'hAAAA);
`endif

        send_ar(64'h40, 8'd7, BURST_INCR, 4'b0001, 1'b0);
        req.r_ready = 1'b1;
        lat = 0;
        while (!rsp.r_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("mrst_beat0", rsp.r.data, 64'hD000_0000_0000_0040);
        tick();
        rst = 1'b1;
        #1;
        chk("mrst_rvalid", 64'(rsp.r_valid), 64'd0);
        chk("mrst_ar_ready", 64'(rsp.ar_ready), 64'd0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("mrst_idle_rvalid", 64'(rsp.r_valid), 64'd0);
        chk("mrst_idle_ar_ready", 64'(rsp.ar_ready), 64'd1);
        req.r_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
